// File: rtl/vmem_pkg.sv
// Shared types for the vector memory responder: lane/word types, FSM states, beat width.
package vmem_pkg;
    localparam int VMEM_LANES  = 16;
    localparam int VMEM_DATA_W = 32;
    localparam int BEAT_W      = $clog2(VMEM_LANES);

    typedef logic [VMEM_DATA_W-1:0] word_t;
    typedef word_t [VMEM_LANES-1:0] vec_t;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} vmem_state_t;
endpackage

// File: rtl/vmem_word_ram.sv
// Single-port word RAM: synchronous write, registered read (1-cycle latency, read-before-write).
module vmem_word_ram #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;
endmodule

// File: rtl/vec_mem_responder.sv
// Serialises one scalar/vector request into per-word RAM beats and assembles a 16-lane response.
// Optional VMEM_ALIGN_CHECK_EN rejects vector requests not aligned to a LANES-word boundary.
module vec_mem_responder
    import vmem_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int LANES     = VMEM_LANES,
    parameter int DATA_W    = VMEM_DATA_W,
    parameter     INIT_FILE = ""
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic                          req_vec,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [LANES-1:0][DATA_W-1:0]  req_wdata,
    output logic                          resp_valid,
    output logic                          resp_err,
    output logic [LANES-1:0][DATA_W-1:0]  resp_rdata
);
    localparam int BW = $clog2(LANES);

    vmem_state_t r_state, w_next;

    logic                         r_write, r_vec;
    logic [ADDR_W-1:0]            r_addr;
    logic [LANES-1:0][DATA_W-1:0] r_wdata, r_asm, r_rdata, w_asm_next;
    logic [BW-1:0]                r_beat, r_cap_lane, w_lane;
    logic                         r_cap_vld;
    logic                         w_accept, w_last, w_misalign;
    logic                         w_ram_we;
    logic [DATA_W-1:0]            w_ram_q;

`ifdef VMEM_ALIGN_CHECK_EN
    logic r_err;
    assign w_misalign = req_vec & (req_addr[BW-1:0] != '0);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept = req_valid & (r_state == IDLE);
    assign w_last   = (r_beat == (r_vec ? BW'(LANES-1) : '0));
    assign w_lane   = BW'(LANES-1) - r_beat;
    assign w_ram_we = (r_state == XFER) & r_write;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_misalign ? RESP : XFER;
            XFER:    if (w_last)   w_next = r_write ? RESP : DRAIN;
            DRAIN:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Read data lags its beat by one cycle; the lane tag travels alongside it.
    always_comb begin
        w_asm_next = r_asm;
        if (r_cap_vld) w_asm_next[r_cap_lane] = w_ram_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_write    <= 1'b0;
            r_vec      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_beat     <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_lane <= '0;
            r_asm      <= '0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_next;
            r_cap_vld  <= (r_state == XFER) & ~r_write;
            r_cap_lane <= w_lane;
            r_asm      <= w_accept ? '0 : w_asm_next;
            if (w_accept) begin
                r_write <= req_write;
                r_vec   <= req_vec;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_beat  <= '0;
            end else if (r_state == XFER) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_beat  <= r_beat + BW'(1);
            end
            // Publish only once the final beat is in, so resp_rdata holds the previous read until now.
            if (r_state == DRAIN) r_rdata <= w_asm_next;
        end
    end

`ifdef VMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_err <= 1'b0;
        else if (w_accept) r_err <= w_misalign;
    end
    assign resp_err = (r_state == RESP) & r_err;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;

    vmem_word_ram #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata[w_lane]),
        .o_rdata (w_ram_q)
    );
endmodule

// File: tb/tb_vec_mem_responder.sv
// Randomised self-checking bench for vec_mem_responder against an array-based memory model.
module tb_vec_mem_responder;
    import vmem_pkg::*;

    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;
    localparam int NL    = VMEM_LANES;

    typedef logic [511:0] cv_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic          req_vec   = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    vec_t          req_wdata = '0;
    logic          req_ready, resp_valid, resp_err;
    vec_t          resp_rdata;

    always #5 clk = ~clk;

    vec_mem_responder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_vec    (req_vec),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata)
    );

    int    n_chk = 0;
    int    n_err = 0;
    word_t mem_m [DEPTH];
    vec_t  rd_m = '0;

    task automatic chk(input string tag, input cv_t got, input cv_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: lane [NL-1-k] <-> word (a+k) mod DEPTH; scalar reads zero the other lanes.
    task automatic model_op(input bit wr, input bit vec, input logic [AW-1:0] a, input vec_t wd);
        int n;
        n = vec ? NL : 1;
        if (wr) begin
            for (int k = 0; k < n; k++) mem_m[(int'(a) + k) % DEPTH] = wd[NL-1-k];
        end else begin
            rd_m = '0;
            for (int k = 0; k < n; k++) rd_m[NL-1-k] = mem_m[(int'(a) + k) % DEPTH];
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < NL; i++) v[i] = $urandom;
        return v;
    endfunction

    task automatic wait_ready(input string tag);
        int c;
        c = 0;
        while (!req_ready && c < 60) begin
            tick;
            c++;
        end
        chk({tag, ":ready"}, cv_t'(req_ready), cv_t'(1));
    endtask

    // Issues one request, returns in the response cycle (or after the timeout).
    task automatic do_req(input string tag, input bit wr, input bit vec,
                          input logic [AW-1:0] a, input vec_t wd, input bit exp_err);
        int cyc, lat;
        wait_ready(tag);
        req_valid = 1'b1;
        req_write = wr;
        req_vec   = vec;
        req_addr  = a;
        req_wdata = wd;
        tick;
        req_valid = 1'b0;
        chk({tag, ":busy"}, cv_t'(req_ready), cv_t'(0));
        lat = exp_err ? 1 : (wr ? (vec ? NL : 1) + 1 : (vec ? NL : 1) + 2);
        cyc = 1;
        while (!resp_valid && cyc < 40) begin
            tick;
            cyc++;
        end
        if (!exp_err) model_op(wr, vec, a, wd);
        chk({tag, ":latency"}, cv_t'(cyc), cv_t'(lat));
        chk({tag, ":err"}, cv_t'(resp_err), cv_t'(exp_err));
        chk({tag, ":rdata"}, cv_t'(resp_rdata), cv_t'(rd_m));
    endtask

    initial begin
        vec_t wd, nd;
        int   cyc;
        bit   wr, vec, ee;
        logic [AW-1:0] a;

        repeat (3) tick;
        chk("rst:ready", cv_t'(req_ready), cv_t'(1));
        chk("rst:valid", cv_t'(resp_valid), cv_t'(0));
        chk("rst:err", cv_t'(resp_err), cv_t'(0));
        chk("rst:rdata", cv_t'(resp_rdata), cv_t'(0));
        rst = 1'b1;
        tick;

        for (int b = 0; b < DEPTH; b += NL) do_req("fill", 1'b1, 1'b1, AW'(b), rand_vec(), 1'b0);

        // scalar write then read
        wd = '0;
        wd[NL-1] = 32'h0000_00AB;
        do_req("t1w", 1'b1, 1'b0, AW'(5), wd, 1'b0);
        do_req("t1r", 1'b0, 1'b0, AW'(5), '0, 1'b0);
        chk("t1:lane15", cv_t'(resp_rdata[NL-1]), cv_t'(32'hAB));
        chk("t1:lower", cv_t'(resp_rdata[NL-2:0]), cv_t'(0));

        // vector round trip
        for (int i = 0; i < NL; i++) wd[i] = 32'(i) * 32'h1111_1111;
        do_req("t2w", 1'b1, 1'b1, AW'(13'h100), wd, 1'b0);
        do_req("t2r", 1'b0, 1'b1, AW'(13'h100), '0, 1'b0);
        chk("t2:vec", cv_t'(resp_rdata), cv_t'(wd));
        do_req("t2s", 1'b0, 1'b0, AW'(13'h100), '0, 1'b0);
        chk("t2:w100", cv_t'(resp_rdata[NL-1]), cv_t'(32'hFFFF_FFFF));

`ifdef VMEM_ALIGN_CHECK_EN
        do_req("t4r", 1'b0, 1'b1, AW'(13'h103), '0, 1'b1);
        tick;
        chk("t4:ready2", cv_t'(req_ready), cv_t'(1));
        do_req("t4w", 1'b1, 1'b1, AW'(13'h103), rand_vec(), 1'b1);
        do_req("t4chk", 1'b0, 1'b1, AW'(13'h100), '0, 1'b0);
        chk("t4:untouched", cv_t'(resp_rdata), cv_t'(wd));
`else
        wd = rand_vec();
        do_req("t3w", 1'b1, 1'b1, AW'(13'h1FF8), wd, 1'b0);
        do_req("t3s", 1'b0, 1'b0, AW'(0), '0, 1'b0);
        chk("t3:w0", cv_t'(resp_rdata[NL-1]), cv_t'(wd[7]));
        do_req("t3r", 1'b0, 1'b1, AW'(13'h1FF8), '0, 1'b0);
        chk("t3:vec", cv_t'(resp_rdata), cv_t'(wd));
        do_req("t4u", 1'b0, 1'b1, AW'(13'h103), '0, 1'b0);
`endif

        // reset in the middle of a vector write, just after beat 5 lands
        nd = rand_vec();
        wait_ready("t5");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_vec   = 1'b1;
        req_addr  = AW'(13'h200);
        req_wdata = nd;
        tick;
        req_valid = 1'b0;
        repeat (6) tick;
        rst = 1'b0;
        #1;
        chk("t5:ready", cv_t'(req_ready), cv_t'(1));
        chk("t5:valid", cv_t'(resp_valid), cv_t'(0));
        chk("t5:err", cv_t'(resp_err), cv_t'(0));
        chk("t5:rdata", cv_t'(resp_rdata), cv_t'(0));
        for (int k = 0; k < 6; k++) mem_m[13'h200 + k] = nd[NL-1-k];
        rd_m = '0;
        #2;
        rst = 1'b1;
        tick;
        do_req("t5r", 1'b0, 1'b1, AW'(13'h200), '0, 1'b0);

        // request held high across two back-to-back scalar reads
        wait_ready("t6");
        req_valid = 1'b1;
        req_write = 1'b0;
        req_vec   = 1'b0;
        req_addr  = AW'(13'h205);
        tick;
        for (int c = 1; c <= 3; c++) begin
            chk("t6:busy", cv_t'(req_ready), cv_t'(0));
            if (c < 3) tick;
        end
        model_op(1'b0, 1'b0, AW'(13'h205), '0);
        chk("t6:resp1", cv_t'(resp_valid), cv_t'(1));
        chk("t6:rdata1", cv_t'(resp_rdata), cv_t'(rd_m));
        tick;
        chk("t6:idle", cv_t'(req_ready), cv_t'(1));
        tick;
        req_valid = 1'b0;
        cyc = 5;
        while (!resp_valid && cyc < 40) begin
            tick;
            cyc++;
        end
        chk("t6:resp2_cycle", cv_t'(cyc), cv_t'(7));
        chk("t6:rdata2", cv_t'(resp_rdata), cv_t'(rd_m));

        for (int i = 0; i < 300; i++) begin
            wr  = 1'($urandom);
            vec = 1'($urandom);
            a   = AW'($urandom);
            ee  = 1'b0;
`ifdef VMEM_ALIGN_CHECK_EN
            ee  = vec && (a[3:0] != 4'h0);
`endif
            do_req("rnd", wr, vec, a, rand_vec(), ee);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
